// File: rtl/serial_sum_collector.sv
// Collects LSB-first serial sum bits plus the final carry into {cout, sum} words
// and hands them to a consumer through a small first-word fall-through FIFO.
module serial_sum_collector #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_valid,
  input  logic             sof,
  input  logic             sum_bit,
  input  logic             carry_bit,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             busy,
  output logic             framing_err,
  output logic             overflow_err
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  if (WIDTH < 2) begin : g_bad_width
    $error("serial_sum_collector: WIDTH must be >= 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("serial_sum_collector: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  typedef struct packed {
    logic             cout;
    logic [WIDTH-1:0] sum;
  } word_t;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] shifted;
  logic             push;
  word_t            push_word;
  logic             ferr_d;

  word_t            mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             full, pop, push_ok, drop, valid_d;
  word_t            head_q, head_d;
  logic             busy_q, ferr_q, ovf_q;

  // Frame assembly: next state, shift register, bit count and push request
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    push      = 1'b0;
    push_word = '0;
    ferr_d    = 1'b0;
    shifted   = {sum_bit, shreg_q[WIDTH-1:1]};
    unique case (state_q)
      IDLE: begin
        if (bit_valid) begin
          if (sof) begin
            shreg_d = shifted;
            cnt_d   = CW'(1);
            state_d = COLLECT;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (bit_valid) begin
          shreg_d = shifted;
          if (sof) begin
            // restart: stale high bits shift out before the frame completes
            ferr_d = 1'b1;
            cnt_d  = CW'(1);
          end else if (cnt_q == CW'(WIDTH - 1)) begin
            push           = 1'b1;
            push_word.cout = carry_bit;
            push_word.sum  = shifted;
            cnt_d          = '0;
            state_d        = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop     = res_valid & res_ready;
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  // Next pointers and the next head word, registered straight onto res_*
  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    valid_d  = (wr_ptr_d != rd_ptr_d);
    head_d   = '0;
    if (valid_d) begin
      if (push_ok && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
        head_d = push_word;
      end else begin
        head_d = mem_q[rd_ptr_d[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shreg_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
      busy_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
      busy_q   <= (state_d == COLLECT);
      ferr_q   <= ferr_d;
      ovf_q    <= ovf_q | drop;
    end
  end

  // Storage needs no reset: entries are only read after being written
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_word;
    end
  end

  assign res_valid    = (wr_ptr_q != rd_ptr_q);
  assign res_sum      = head_q.sum;
  assign res_cout     = head_q.cout;
  assign busy         = busy_q;
  assign framing_err  = ferr_q;
  assign overflow_err = ovf_q;

endmodule
